// File: rtl/ir_fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: instruction width, reset PC default, NOP word, fetch-entry struct
// and a word-alignment helper.
package ir_fetch_queue_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] IFQ_RESET_PC = 32'h0000_3000;
  localparam logic [XLEN-1:0] IFQ_NOP      = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] ir;
  } fetch_ent_t;

  // Clear the byte offset of an address.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return a & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/ir_fetch_queue_ifq_fifo.sv
// Generic synchronous FIFO with push, pop, clear and occupancy count.
// Latency: a pushed word is readable at head_o the cycle after the push.
// Backpressure: push while full is accepted only together with a pop.
//
// Ports: clk, rst_n (async active-low); clear_i empties the FIFO (wins over
// push/pop); push_i/push_dat_i write the tail; pop_i drops the head;
// head_o shows the oldest entry; count_o is the number of valid entries.
module ifq_fifo #(
  parameter int unsigned W     = 64,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear_i,
  input  logic          push_i,
  input  logic [W-1:0]  push_dat_i,
  input  logic          pop_i,
  output logic [W-1:0]  head_o,
  output logic [CW-1:0] count_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full, empty, push_ok, pop_ok;

  // Pointers wrap explicitly so non power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push_i & (~full | pop_i);
  assign pop_ok  = pop_i & ~empty;
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_ok)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read once written.
  always_ff @(posedge clk) begin
    if (push_ok && !clear_i) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/ir_fetch_queue.sv
// Fetch PC owner: issues in-order imem word reads, queues returned words with
// their PCs and hands them to decode. Redirect flushes, halt stops issue.
// Latency: response to ir_valid is 1 cycle (0 with IFQ_BYPASS_EN defined).
// Backpressure: ir_ready low fills the queue; issue stops by credit check.
//
// Optional macro IFQ_BYPASS_EN: an undiscarded response arriving while the
// queue is empty is shown to decode combinationally in the same cycle.
//
// Ports: clk, rst_n (async active-low); imem_req/imem_addr/imem_gnt request
// channel; imem_rvalid/imem_rdata in-order responses; ir_valid/ir_ready/ir/
// ir_pc decode handshake; redirect/redirect_pc flush and restart; halt stops
// issue; occupancy counts valid queued entries.
module ir_fetch_queue
  import ir_fetch_queue_pkg::*;
#(
  parameter int unsigned     DEPTH    = 4,
  parameter int unsigned     MAX_OUT  = 2,
  parameter logic [XLEN-1:0] RESET_PC = IFQ_RESET_PC
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic                     imem_req,
  output logic [XLEN-1:0]          imem_addr,
  input  logic                     imem_gnt,
  input  logic                     imem_rvalid,
  input  logic [XLEN-1:0]          imem_rdata,
  output logic                     ir_valid,
  input  logic                     ir_ready,
  output logic [XLEN-1:0]          ir,
  output logic [XLEN-1:0]          ir_pc,
  input  logic                     redirect,
  input  logic [XLEN-1:0]          redirect_pc,
  input  logic                     halt,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  // The head lives in the output register, so the FIFO holds one less.
  localparam int unsigned QD = DEPTH - 1;
  localparam int unsigned EW = $clog2(QD) + 1;
  localparam int unsigned TW = $clog2(MAX_OUT) + 1;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   disc_q, disc_d;
  logic            hv_q, hv_d;
  logic [XLEN-1:0] ir_q, ir_d;
  logic [XLEN-1:0] ir_pc_q, ir_pc_d;
  logic            run_q;

  logic            eq_push, eq_pop;
  fetch_ent_t      eq_dat, eq_head;
  logic [EW-1:0]   eq_cnt;
  logic            tg_pop;
  logic [XLEN-1:0] tg_head;
  logic [TW-1:0]   tg_cnt;

  logic [CW-1:0]   outstanding, occ;
  logic            credit_ok, gnt_ok, rsp_keep, head_pop, byp, byp_take;

  // Tags of discarded requests are flushed on redirect, so in-flight
  // requests are the still-tagged ones plus those awaiting discard.
  assign outstanding = CW'(tg_cnt) + disc_q;
  assign occ         = CW'(eq_cnt) + CW'(hv_q);
  assign occupancy   = occ;
  assign credit_ok   = ({1'b0, occ} + {1'b0, outstanding}) < (CW + 1)'(DEPTH);

  // run_q keeps the request low until the first edge after reset release.
  assign imem_req  = run_q & ~halt & ~redirect & credit_ok &
                     (outstanding < CW'(MAX_OUT));
  assign imem_addr = pc_q;
  assign gnt_ok    = imem_req & imem_gnt;
  assign tg_pop    = imem_rvalid & (disc_q == '0);
  assign rsp_keep  = tg_pop & ~redirect;
  assign head_pop  = hv_q & ir_ready;

`ifdef IFQ_BYPASS_EN
  assign byp      = rsp_keep & ~hv_q;
  assign byp_take = byp & ir_ready;
  assign ir_valid = hv_q | byp;
  assign ir       = byp ? imem_rdata : ir_q;
  assign ir_pc    = byp ? tg_head : ir_pc_q;
`else
  assign byp      = 1'b0;
  assign byp_take = 1'b0;
  assign ir_valid = hv_q;
  assign ir       = ir_q;
  assign ir_pc    = ir_pc_q;
`endif

  always_comb begin
    pc_d    = pc_q;
    disc_d  = disc_q;
    hv_d    = hv_q;
    ir_d    = ir_q;
    ir_pc_d = ir_pc_q;
    eq_push = 1'b0;
    eq_pop  = 1'b0;
    eq_dat  = '{pc: tg_head, ir: imem_rdata};
    if (redirect) begin
      pc_d   = word_align(redirect_pc);
      // A response landing this cycle is dropped with the flush.
      disc_d = outstanding - CW'(imem_rvalid);
      hv_d   = 1'b0;
    end else begin
      if (gnt_ok) pc_d = pc_q + 32'd4;
      if (imem_rvalid && disc_q != '0) disc_d = disc_q - CW'(1);
      if (!hv_q || head_pop) begin
        if (eq_cnt != '0) begin
          hv_d    = 1'b1;
          ir_d    = eq_head.ir;
          ir_pc_d = eq_head.pc;
          eq_pop  = 1'b1;
          eq_push = rsp_keep;
        end else if (rsp_keep) begin
          // A bypassed word consumed now is not kept, but ir/ir_pc still
          // latch it so they hold the last word shown.
          hv_d    = ~byp_take;
          ir_d    = imem_rdata;
          ir_pc_d = tg_head;
        end else begin
          hv_d = 1'b0;
        end
      end else begin
        eq_push = rsp_keep;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      disc_q  <= '0;
      hv_q    <= 1'b0;
      ir_q    <= IFQ_NOP;
      ir_pc_q <= '0;
      run_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      disc_q  <= disc_d;
      hv_q    <= hv_d;
      ir_q    <= ir_d;
      ir_pc_q <= ir_pc_d;
      run_q   <= 1'b1;
    end
  end

  ifq_fifo #(.W($bits(fetch_ent_t)), .DEPTH(QD), .CW(EW)) u_entry_q (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (redirect),
    .push_i     (eq_push),
    .push_dat_i (eq_dat),
    .pop_i      (eq_pop),
    .head_o     (eq_head),
    .count_o    (eq_cnt)
  );

  // PC of each tagged in-flight request, oldest first.
  ifq_fifo #(.W(XLEN), .DEPTH(MAX_OUT), .CW(TW)) u_tag_q (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (redirect),
    .push_i     (gnt_ok),
    .push_dat_i (pc_q),
    .pop_i      (tg_pop),
    .head_o     (tg_head),
    .count_o    (tg_cnt)
  );

endmodule

// File: tb/tb_ir_fetch_queue.sv
module tb_ir_fetch_queue;

  localparam int DEPTH   = 4;
  localparam int MAX_OUT = 2;
  localparam logic [31:0] RST_PC = 32'h0000_3000;
`ifdef IFQ_BYPASS_EN
  localparam int LAT = 1;
  localparam bit BYP = 1'b1;
`else
  localparam int LAT = 2;
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        ir_valid, ir_ready;
  logic [31:0] ir, ir_pc;
  logic        redirect, halt;
  logic [31:0] redirect_pc;
  logic [2:0]  occupancy;

  ir_fetch_queue #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .ir_valid(ir_valid), .ir_ready(ir_ready), .ir(ir), .ir_pc(ir_pc),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; bit kept; int due; } fl_t;
  typedef struct { logic [31:0] pc; logic [31:0] ir; int cyc; } lg_t;

  fl_t inflight[$];
  lg_t q[$];
  lg_t grant_log[$];
  lg_t pop_log[$];

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  // knobs
  int gnt_pct = 100, ready_pct = 100, lat_min = 1, lat_max = 1;
  bit rand_mode = 0, halt_v = 0, halt_after_grant = 0;
  int force_mode = 0;
  logic [31:0] force_pc = '0;
  int redir_cyc = -10;
  bit fired = 0;
  logic post_valid = 1'b1;

  logic [31:0] m_pc, last_ir, last_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h2408_3005;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic lg_t nth_after(input lg_t lq[$], input int c, input int k);
    lg_t bad;
    int n = 0;
    bad.pc = 32'hBAD0_BAD0; bad.ir = 32'hBAD0_BAD0; bad.cyc = -1000;
    foreach (lq[i]) begin
      if (lq[i].cyc > c) begin
        if (n == k) return lq[i];
        n++;
      end
    end
    return bad;
  endfunction

  // Drive, then compare and advance the reference model, every cycle.
  initial begin : loop
    bit rv, g, popd, byp, exp_valid, exp_req;
    logic [31:0] exp_ir, exp_pc;
    fl_t f;
    lg_t e;
    redirect = 0; halt = 0; ir_ready = 0; imem_gnt = 0; imem_rvalid = 0;
    imem_rdata = 0; redirect_pc = 0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (!rst_n) begin
        q.delete(); inflight.delete();
        m_pc = RST_PC; last_ir = 0; last_pc = 0;
        redirect = 0; halt = 0; ir_ready = 0; imem_gnt = 0;
        imem_rvalid = 0; imem_rdata = 0; redirect_pc = 0;
      end else begin
        if (rand_mode && $urandom_range(99) < 5) halt_v = ~halt_v;
        halt     = halt_v;
        ir_ready = ($urandom_range(99) < ready_pct);
        imem_gnt = ($urandom_range(99) < gnt_pct);
        rv = (inflight.size() > 0) && (inflight[0].due <= cyc);
        imem_rvalid = rv;
        imem_rdata  = rv ? mem_word(inflight[0].pc) : $urandom();
        redirect = 0;
        redirect_pc = $urandom();
        if (force_mode == 2 || (force_mode == 1 && inflight.size() == 2 && rv)) begin
          redirect = 1; redirect_pc = force_pc; force_mode = 0;
          fired = 1; redir_cyc = cyc;
        end else if (rand_mode && $urandom_range(99) < 3) begin
          redirect = 1;
        end
      end

      @(negedge clk);
      if (!rst_n) begin
        chk("rst_imem_req", {31'b0, imem_req}, 32'd0);
        chk("rst_ir_valid", {31'b0, ir_valid}, 32'd0);
        chk("rst_ir", ir, 32'd0);
        chk("rst_ir_pc", ir_pc, 32'd0);
        chk("rst_occupancy", {29'b0, occupancy}, 32'd0);
      end else begin
        byp = BYP && q.size() == 0 && imem_rvalid && inflight[0].kept && !redirect;
        exp_valid = (q.size() > 0) || byp;
        exp_ir = (q.size() > 0) ? q[0].ir : (byp ? mem_word(inflight[0].pc) : last_ir);
        exp_pc = (q.size() > 0) ? q[0].pc : (byp ? inflight[0].pc : last_pc);
        exp_req = !halt && !redirect && (q.size() + inflight.size() < DEPTH) &&
                  (inflight.size() < MAX_OUT);
        chk("ir_valid", {31'b0, ir_valid}, {31'b0, exp_valid});
        chk("ir", ir, exp_ir);
        chk("ir_pc", ir_pc, exp_pc);
        chk("occupancy", {29'b0, occupancy}, q.size());
        chk("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
        if (exp_req) chk("imem_addr", imem_addr, m_pc);
        if (cyc == redir_cyc + 1) post_valid = ir_valid;

        g = exp_req && imem_gnt;
        rv = imem_rvalid;
        popd = ir_ready && exp_valid;
        if (exp_valid) begin last_ir = exp_ir; last_pc = exp_pc; end
        if (redirect) begin
          q.delete();
          if (rv) void'(inflight.pop_front());
          foreach (inflight[i]) inflight[i].kept = 0;
          m_pc = redirect_pc & ~32'd3;
        end else begin
          if (popd) begin
            e.pc = exp_pc; e.ir = exp_ir; e.cyc = cyc;
            pop_log.push_back(e);
            if (q.size() > 0) void'(q.pop_front());
          end
          if (rv) begin
            f = inflight.pop_front();
            if (f.kept && !(byp && popd)) begin
              e.pc = f.pc; e.ir = mem_word(f.pc); e.cyc = cyc;
              q.push_back(e);
            end
          end
          if (g) begin
            e.pc = m_pc; e.ir = 0; e.cyc = cyc;
            grant_log.push_back(e);
            f.pc = m_pc; f.kept = 1; f.due = cyc + $urandom_range(lat_max, lat_min);
            inflight.push_back(f);
            if (halt_after_grant) begin halt_v = 1; halt_after_grant = 0; end
            m_pc = m_pc + 32'd4;
          end
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    wait_cyc(3);
    grant_log.delete(); pop_log.delete();
    force_mode = 0; halt_after_grant = 0; halt_v = 0; fired = 0;
    redir_cyc = -10; post_valid = 1'b1; rand_mode = 0;
    rst_n = 1'b1;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    lg_t a, b;
    // Streaming from reset: grant every cycle, 1-cycle memory latency.
    gnt_pct = 100; ready_pct = 100; lat_min = 1; lat_max = 1;
    do_reset();
    wait_cyc(12);
    for (int k = 0; k < 3; k++) begin
      a = nth_after(grant_log, 0, k);
      b = nth_after(pop_log, 0, k);
      chk("stream_grant_addr", a.pc, RST_PC + 32'(4 * k));
      chk("stream_pop_pc", b.pc, RST_PC + 32'(4 * k));
      chk("stream_latency", 32'(b.cyc - a.cyc), 32'(LAT));
    end
    b = nth_after(pop_log, 0, 0);
    chk("stream_first_ir", b.ir, 32'h2408_0005);

    // Decode stalled: queue fills to DEPTH then issue stops.
    ready_pct = 0;
    do_reset();
    wait_cyc(12);
    chk("stall_grants", grant_log.size(), 32'd4);
    chk("stall_occupancy", {29'b0, occupancy}, 32'd4);
    chk("stall_req_low", {31'b0, imem_req}, 32'd0);
    ready_pct = 100;
    wait_cyc(12);
    chk("stall_resume", {31'b0, grant_log.size() > 4}, 32'd1);
    for (int k = 0; k < 5; k++) begin
      b = nth_after(pop_log, 0, k);
      chk("stall_order", b.pc, RST_PC + 32'(4 * k));
    end

    // Redirect with two outstanding, one returning in the redirect cycle.
    lat_min = 2; lat_max = 2;
    do_reset();
    force_mode = 1; force_pc = 32'h0000_4002;
    wait_cyc(14);
    chk("redir_fired", {31'b0, fired}, 32'd1);
    chk("redir_flush_valid", {31'b0, post_valid}, 32'd0);
    a = nth_after(grant_log, redir_cyc, 0);
    chk("redir_next_addr", a.pc, 32'h0000_4000);
    b = nth_after(pop_log, 0, 0);
    chk("redir_first_pop_pc", b.pc, 32'h0000_4000);
    chk("redir_first_pop_ir", b.ir, mem_word(32'h0000_4000));

    // Halt right after the first grant: that word still arrives.
    lat_min = 3; lat_max = 3;
    do_reset();
    halt_after_grant = 1;
    wait_cyc(12);
    chk("halt_grants", grant_log.size(), 32'd1);
    chk("halt_pops", pop_log.size(), 32'd1);
    b = nth_after(pop_log, 0, 0);
    chk("halt_pop_pc", b.pc, RST_PC);
    halt_v = 0;
    wait_cyc(8);
    a = nth_after(grant_log, 0, 1);
    chk("halt_resume_addr", a.pc, RST_PC + 32'd4);

    // PC wrap at the top of the address space.
    lat_min = 1; lat_max = 1;
    force_mode = 2; force_pc = 32'hFFFF_FFFC;
    wait_cyc(10);
    a = nth_after(grant_log, redir_cyc, 0);
    chk("wrap_addr0", a.pc, 32'hFFFF_FFFC);
    a = nth_after(grant_log, redir_cyc, 1);
    chk("wrap_addr1", a.pc, 32'h0000_0000);

    // Randomized traffic against the reference model.
    do_reset();
    rand_mode = 1;
    for (int blk = 0; blk < 20; blk++) begin
      gnt_pct   = $urandom_range(100, 30);
      ready_pct = $urandom_range(100, 20);
      lat_min   = 1;
      lat_max   = $urandom_range(4, 1);
      wait_cyc(200);
    end
    rand_mode = 0; halt_v = 0;
    wait_cyc(5);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
